gpfc_pause_controller: RTL and testbench

Receive-side counterpart of the GPFC congestion monitor. It accepts pause messages (rank, time) from the link peer and holds a per-link pause state with a quanta-based countdown timer. It gates the root PIFO dequeue path: only ranks allowed by the current pause state may leave. It sits between the GPFC frame parser and the scheduler's dequeue arbiter.

---
 rtl/gpfc_pkg.sv | 14 +
 rtl/gpfc_pause_timer.sv | 51 +++++
 rtl/gpfc_pause_controller.sv | 114 +++++++++++
 tb/tb_gpfc_pause_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gpfc_pkg.sv
// Shared GPFC definitions: pause-state encoding and the pause message special values.
// Used by both the pause controller and the congestion monitor.
package gpfc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PAUSE_LOW = 2'd1,
        PAUSE_ALL = 2'd2
    } gpfc_state_e;

    localparam int unsigned PAUSE_RANK_ALL    = 0;
    localparam int unsigned PAUSE_TIME_RESUME = 0;

endpackage

// File: rtl/gpfc_pause_timer.sv
// Quanta countdown: a prescaler of QUANTA_CYCLES cycles per quantum plus a remaining-quanta counter.
// expire_c pulses in the last cycle of the last quantum unless a load or clear overrides it.
module gpfc_pause_timer
    import gpfc_pkg::*;
#(
    parameter int unsigned TIME_WIDTH    = 16,
    parameter int unsigned QUANTA_CYCLES = 512
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [TIME_WIDTH-1:0] load_value,
    input  logic                  clear,
    output logic                  expire_c,
    output logic [TIME_WIDTH-1:0] remaining
);

    localparam int unsigned PRE_WIDTH = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [PRE_WIDTH-1:0] PRE_RELOAD = PRE_WIDTH'(QUANTA_CYCLES - 1);

    logic [PRE_WIDTH-1:0] prescaler;
    logic                 running;
    logic                 quantum_end;

    assign running     = (remaining != '0);
    assign quantum_end = running && (prescaler == '0);
    assign expire_c    = quantum_end && (remaining == TIME_WIDTH'(1)) && !load && !clear;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prescaler <= '0;
            remaining <= '0;
        end else if (load) begin
            prescaler <= PRE_RELOAD;
            remaining <= load_value;
        end else if (clear) begin
            prescaler <= '0;
            remaining <= '0;
        end else if (running) begin
            if (prescaler != '0) begin
                prescaler <= prescaler - PRE_WIDTH'(1);
            end else if (remaining == TIME_WIDTH'(1)) begin
                remaining <= '0;
            end else begin
                remaining <= remaining - TIME_WIDTH'(1);
                prescaler <= PRE_RELOAD;
            end
        end
    end

endmodule

// File: rtl/gpfc_pause_controller.sv
// Receive-side GPFC pause controller: tracks peer pause messages and gates PIFO dequeue by rank.
// Define GPFC_PAUSE_STATS_EN to add saturating pause-event and blocked-cycle counters.
module gpfc_pause_controller
    import gpfc_pkg::*;
#(
    parameter int unsigned PAUSE_RANK_WIDTH = 16,
    parameter int unsigned PAUSE_TIME_WIDTH = 16,
    parameter int unsigned QUANTA_CYCLES    = 512
`ifdef GPFC_PAUSE_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH       = 32
`endif
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_axis_valid,
    input  logic [PAUSE_RANK_WIDTH-1:0] s_axis_pause_rank,
    input  logic [PAUSE_TIME_WIDTH-1:0] s_axis_pause_time,
    input  logic                        s_deq_valid,
    input  logic [PAUSE_RANK_WIDTH-1:0] s_deq_rank,
    output logic                        m_deq_ready,
    output logic                        m_paused,
    output logic                        m_pause_all,
    output logic [PAUSE_RANK_WIDTH-1:0] m_rank_threshold,
    output logic [PAUSE_TIME_WIDTH-1:0] m_remaining
`ifdef GPFC_PAUSE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]       m_stat_pause_events,
    output logic [STAT_WIDTH-1:0]       m_stat_blocked_cycles
`endif
);

    gpfc_state_e state_q;
    gpfc_state_e state_d;
    logic        msg_pause;
    logic        msg_resume;
    logic        timer_expire;

    assign msg_pause  = s_axis_valid && (s_axis_pause_time != PAUSE_TIME_WIDTH'(PAUSE_TIME_RESUME));
    assign msg_resume = s_axis_valid && (s_axis_pause_time == PAUSE_TIME_WIDTH'(PAUSE_TIME_RESUME));

    gpfc_pause_timer #(
        .TIME_WIDTH    (PAUSE_TIME_WIDTH),
        .QUANTA_CYCLES (QUANTA_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load       (msg_pause),
        .load_value (s_axis_pause_time),
        .clear      (msg_resume),
        .expire_c   (timer_expire),
        .remaining  (m_remaining)
    );

    // State register with the registered status outputs derived from the next state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= IDLE;
            m_paused         <= 1'b0;
            m_pause_all      <= 1'b0;
            m_rank_threshold <= '0;
        end else begin
            state_q     <= state_d;
            m_paused    <= (state_d != IDLE);
            m_pause_all <= (state_d == PAUSE_ALL);
            if (msg_pause) begin
                m_rank_threshold <= s_axis_pause_rank;
            end else if (msg_resume || timer_expire) begin
                m_rank_threshold <= '0;
            end
        end
    end

    // Next state: a message always wins over a same-cycle timer expiry
    always_comb begin
        state_d = state_q;
        if (msg_pause) begin
            state_d = (s_axis_pause_rank == PAUSE_RANK_WIDTH'(PAUSE_RANK_ALL)) ? PAUSE_ALL : PAUSE_LOW;
        end else if (msg_resume || timer_expire) begin
            state_d = IDLE;
        end
    end

    // Dequeue gating, zero latency from s_deq_rank
    always_comb begin
        m_deq_ready = 1'b1;
        case (state_q)
            IDLE:      m_deq_ready = 1'b1;
            PAUSE_LOW: m_deq_ready = (s_deq_rank < m_rank_threshold);
            PAUSE_ALL: m_deq_ready = 1'b0;
            default:   m_deq_ready = 1'b1;
        endcase
    end

`ifdef GPFC_PAUSE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_stat_pause_events   <= '0;
            m_stat_blocked_cycles <= '0;
        end else begin
            if (msg_pause && (m_stat_pause_events != '1)) begin
                m_stat_pause_events <= m_stat_pause_events + STAT_WIDTH'(1);
            end
            if (s_deq_valid && !m_deq_ready && (m_stat_blocked_cycles != '1)) begin
                m_stat_blocked_cycles <= m_stat_blocked_cycles + STAT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_deq_valid;
    assign unused_deq_valid = s_deq_valid;
`endif

endmodule

// File: tb/tb_gpfc_pause_controller.sv
// Directed bench for gpfc_pause_controller with QUANTA_CYCLES=4.
// Stats counters are checked as well when GPFC_PAUSE_STATS_EN is defined.
module tb_gpfc_pause_controller;

    localparam int unsigned RW = 16;
    localparam int unsigned TW = 16;
    localparam int unsigned QC = 4;

    logic          clk;
    logic          rstn;
    logic          s_axis_valid;
    logic [RW-1:0] s_axis_pause_rank;
    logic [TW-1:0] s_axis_pause_time;
    logic          s_deq_valid;
    logic [RW-1:0] s_deq_rank;
    logic          m_deq_ready;
    logic          m_paused;
    logic          m_pause_all;
    logic [RW-1:0] m_rank_threshold;
    logic [TW-1:0] m_remaining;
`ifdef GPFC_PAUSE_STATS_EN
    logic [31:0]   m_stat_pause_events;
    logic [31:0]   m_stat_blocked_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    gpfc_pause_controller #(
        .PAUSE_RANK_WIDTH (RW),
        .PAUSE_TIME_WIDTH (TW),
        .QUANTA_CYCLES    (QC)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .s_axis_valid      (s_axis_valid),
        .s_axis_pause_rank (s_axis_pause_rank),
        .s_axis_pause_time (s_axis_pause_time),
        .s_deq_valid       (s_deq_valid),
        .s_deq_rank        (s_deq_rank),
        .m_deq_ready       (m_deq_ready),
        .m_paused          (m_paused),
        .m_pause_all       (m_pause_all),
        .m_rank_threshold  (m_rank_threshold),
        .m_remaining       (m_remaining)
`ifdef GPFC_PAUSE_STATS_EN
        ,
        .m_stat_pause_events   (m_stat_pause_events),
        .m_stat_blocked_cycles (m_stat_blocked_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ready_for(input logic [RW-1:0] rank, input logic exp, input string tag);
        s_deq_rank = rank;
        #1;
        chk(tag, 32'(m_deq_ready), 32'(exp));
    endtask

    task automatic send(input logic [RW-1:0] rank, input logic [TW-1:0] t);
        s_axis_valid      = 1'b1;
        s_axis_pause_rank = rank;
        s_axis_pause_time = t;
        tick();
        s_axis_valid      = 1'b0;
    endtask

    initial begin
        rstn              = 1'b0;
        s_axis_valid      = 1'b0;
        s_axis_pause_rank = '0;
        s_axis_pause_time = '0;
        s_deq_valid       = 1'b0;
        s_deq_rank        = '0;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reset state, idle gating
        chk("rst_paused", 32'(m_paused), 32'd0);
        chk("rst_pause_all", 32'(m_pause_all), 32'd0);
        chk("rst_remaining", 32'(m_remaining), 32'd0);
        chk("rst_threshold", 32'(m_rank_threshold), 32'd0);
        ready_for(16'd0, 1'b1, "rst_ready_r0");
        ready_for(16'd8, 1'b1, "rst_ready_r8");
        ready_for(16'hFFFF, 1'b1, "rst_ready_rmax");

        // PAUSE_LOW rank 8, 3 quanta: blocked exactly 12 cycles
        send(16'd8, 16'd3);
        for (int i = 1; i <= 12; i++) begin
            chk("low_paused", 32'(m_paused), 32'd1);
            chk("low_pause_all", 32'(m_pause_all), 32'd0);
            chk("low_remaining", 32'(m_remaining), 32'(3 - (i - 1) / 4));
            ready_for(16'd7, 1'b1, "low_ready_r7");
            ready_for(16'd8, 1'b0, "low_ready_r8");
            ready_for(16'd200, 1'b0, "low_ready_r200");
            tick();
        end
        chk("low_end_paused", 32'(m_paused), 32'd0);
        chk("low_end_remaining", 32'(m_remaining), 32'd0);
        chk("low_end_threshold", 32'(m_rank_threshold), 32'd0);
        ready_for(16'd200, 1'b1, "low_end_ready_r200");

        // PAUSE_ALL 2 quanta with dequeue requests held every cycle
        s_deq_valid = 1'b1;
        s_deq_rank  = 16'd0;
        send(16'd0, 16'd2);
        for (int i = 1; i <= 8; i++) begin
            chk("all_pause_all", 32'(m_pause_all), 32'd1);
            ready_for(16'd0, 1'b0, "all_ready_r0");
            tick();
        end
        chk("all_end_pause_all", 32'(m_pause_all), 32'd0);
        ready_for(16'd0, 1'b1, "all_end_ready_r0");
        s_deq_valid = 1'b0;

        // Override PAUSE_LOW by PAUSE_ALL mid-pause, then resume with T=0
        send(16'd8, 16'd3);
        tick();
        tick();
        chk("ovr_low_threshold", 32'(m_rank_threshold), 32'd8);
        send(16'd0, 16'd5);
        chk("ovr_pause_all", 32'(m_pause_all), 32'd1);
        chk("ovr_remaining", 32'(m_remaining), 32'd5);
        chk("ovr_threshold", 32'(m_rank_threshold), 32'd0);
        send(16'd3, 16'd0);
        chk("resume_paused", 32'(m_paused), 32'd0);
        chk("resume_remaining", 32'(m_remaining), 32'd0);
        ready_for(16'd100, 1'b1, "resume_ready");

        // New message in the exact cycle the timer expires
        send(16'd8, 16'd1);
        tick();
        tick();
        tick();
        chk("col_last_remaining", 32'(m_remaining), 32'd1);
        chk("col_last_paused", 32'(m_paused), 32'd1);
        send(16'd5, 16'd4);
        chk("col_paused", 32'(m_paused), 32'd1);
        chk("col_remaining", 32'(m_remaining), 32'd4);
        chk("col_threshold", 32'(m_rank_threshold), 32'd5);
        ready_for(16'd4, 1'b1, "col_ready_r4");
        ready_for(16'd5, 1'b0, "col_ready_r5");

        // Maximum pause time, then reset mid PAUSE_ALL
        send(16'd0, 16'hFFFF);
        chk("max_remaining", 32'(m_remaining), 32'h0000FFFF);
        chk("max_pause_all", 32'(m_pause_all), 32'd1);
`ifdef GPFC_PAUSE_STATS_EN
        chk("stat_events", m_stat_pause_events, 32'd7);
        chk("stat_blocked", m_stat_blocked_cycles, 32'd8);
`endif
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst2_paused", 32'(m_paused), 32'd0);
        chk("rst2_pause_all", 32'(m_pause_all), 32'd0);
        chk("rst2_remaining", 32'(m_remaining), 32'd0);
        chk("rst2_threshold", 32'(m_rank_threshold), 32'd0);
        ready_for(16'd0, 1'b1, "rst2_ready_r0");
`ifdef GPFC_PAUSE_STATS_EN
        chk("rst2_stat_events", m_stat_pause_events, 32'd0);
        chk("rst2_stat_blocked", m_stat_blocked_cycles, 32'd0);
`endif
        tick();
        chk("post_rst_paused", 32'(m_paused), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
